// File: rtl/store_unit_pkg.sv
// store_unit_pkg: FSM state encoding and funct3 store encodings shared by the store unit.
package pkg_store_unit;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
endpackage

// File: rtl/store_unit_lane_align.sv
// store_lane_align: shifts store data and byte mask into a two-word lane window.
module store_lane_align
  import pkg_store_unit::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [63:0] wdata,
  output logic [7:0]  strobe,
  output logic        bad
);
  logic [3:0] mask;
  always_comb begin
    mask = funct3 == F3_SB ? 4'b0001 : funct3 == F3_SH ? 4'b0011 : funct3 == F3_SW ? 4'b1111 : 4'b0000;
    bad = mask == 4'b0000;
    wdata = {32'b0, data} << {off, 3'b000};
    strobe = {4'b0, mask} << off;
  end
endmodule

// File: rtl/store_unit.sv
// store_unit: turns a core store into one or two word-aligned memory write beats.
// Macro STORE_SPLIT_MISALIGNED_EN enables the second beat for word-crossing stores.
module store_unit
  import pkg_store_unit::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [2:0]            req_funct3,
  output logic                  done,
  output logic                  err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb
);
`ifdef STORE_SPLIT_MISALIGNED_EN
  localparam int DW = 64;
`else
  localparam int DW = 32;
`endif
  state_t state, nxt;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [DW-1:0] data_q;
  logic [DW/8-1:0] strb_q;
  logic err_q, bad, reject, has_hi, beat0, beat1;
  logic [63:0] al_data;
  logic [7:0] al_strb;

  store_lane_align u_align (
    .off(req_addr[1:0]),
    .funct3(req_funct3),
    .data(req_data),
    .wdata(al_data),
    .strobe(al_strb),
    .bad(bad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr[ADDR_WIDTH-1:2];
        data_q <= al_data[DW-1:0];
        strb_q <= al_strb[DW/8-1:0];
        err_q <= reject;
      end
    end
  end

  always_comb begin
    nxt = state == IDLE  ? (req_valid ? (reject ? RESP : BEAT0) : IDLE) :
          state == BEAT0 ? (mem_ready ? (has_hi ? BEAT1 : RESP) : BEAT0) :
          state == BEAT1 ? (mem_ready ? RESP : BEAT1) : IDLE;
    beat0 = state == BEAT0;
    beat1 = state == BEAT1;
    req_ready = state == IDLE;
    done = state == RESP;
    err = done & err_q;
  end

`ifdef STORE_SPLIT_MISALIGNED_EN
  always_comb begin
    reject = bad;
    has_hi = |strb_q[7:4];
    mem_valid = beat0 | beat1;
    mem_addr = beat0 ? {addr_q, 2'b00} : beat1 ? {addr_q + (ADDR_WIDTH-2)'(1), 2'b00} : '0;
    mem_wdata = beat0 ? data_q[31:0] : beat1 ? data_q[63:32] : '0;
    mem_wstrb = beat0 ? strb_q[3:0] : beat1 ? strb_q[7:4] : '0;
  end
`else
  // Upper lane data is only needed by the second beat, which this build omits.
  logic unused_hi;
  assign unused_hi = ^{al_data[63:32], beat1};
  always_comb begin
    reject = bad | (|al_strb[7:4]);
    has_hi = 1'b0;
    mem_valid = beat0;
    mem_addr = beat0 ? {addr_q, 2'b00} : '0;
    mem_wdata = beat0 ? data_q : '0;
    mem_wstrb = beat0 ? strb_q : '0;
  end
`endif
endmodule
